axis_dac_playout: RTL and testbench

//  Drains 256-bit sample words from the upstream AXIS sync FIFO and plays a burst of exactly
//  NUM_WORDS words onto the DAC data bus, one word per axis_clk.

---
 rtl/axis_dac_playout.sv | 107 ++++++++++
 tb/tb_axis_dac_playout.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dac_playout.sv
// Burst playout from an AXIS sample FIFO onto the DAC data bus.
// A trigger starts a burst of num_words words; FIFO gaps during a burst are flagged as underflow.
module axis_dac_playout #(
  parameter int unsigned          DATA_W    = 256,
  parameter int unsigned          LEN_W     = 16,
  parameter logic [DATA_W-1:0]    IDLE_WORD = '0
) (
  input  logic              axis_clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic              abort,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              clear_underflow,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] dac_tdata,
  output logic              dac_tvalid,
  output logic              busy,
  output logic              done,
  output logic              underflow,
  output logic [LEN_W-1:0]  words_left
);

  typedef enum logic [1:0] {StIdle, StPlay, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dac_tdata_q, dac_tdata_d;
  logic              dac_tvalid_q, dac_tvalid_d;
  logic              done_q, done_d;
  logic              underflow_q, underflow_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic              accept;

  // abort wins over a same-cycle read, so it gates the read strobe directly
  assign s_axis_tready = (state_q == StPlay) && !abort;
  assign accept        = s_axis_tready && s_axis_tvalid;

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    dac_tvalid_d = accept;
    dac_tdata_d  = accept ? s_axis_tdata : IDLE_WORD;

    underflow_d = underflow_q;
    if (clear_underflow) begin
      underflow_d = 1'b0;
    end
    if (s_axis_tready && !s_axis_tvalid) begin
      underflow_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          words_left_d = num_words;
          state_d      = (num_words == '0) ? StDone : StPlay;
        end
      end
      StPlay: begin
        if (abort) begin
          state_d      = StIdle;
          words_left_d = '0;
        end else if (accept) begin
          words_left_d = words_left_q - LEN_W'(1);
          if (words_left_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    done_d = (state_d == StDone);
  end

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      dac_tdata_q  <= IDLE_WORD;
      dac_tvalid_q <= 1'b0;
      done_q       <= 1'b0;
      underflow_q  <= 1'b0;
      words_left_q <= '0;
    end else begin
      state_q      <= state_d;
      dac_tdata_q  <= dac_tdata_d;
      dac_tvalid_q <= dac_tvalid_d;
      done_q       <= done_d;
      underflow_q  <= underflow_d;
      words_left_q <= words_left_d;
    end
  end

  assign dac_tdata  = dac_tdata_q;
  assign dac_tvalid = dac_tvalid_q;
  assign done       = done_q;
  assign underflow  = underflow_q;
  assign words_left = words_left_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_axis_dac_playout.sv
// Bench for axis_dac_playout: behavioural burst model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_axis_dac_playout;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              trigger = 1'b0;
  logic              abort = 1'b0;
  logic [LEN_W-1:0]  num_words = '0;
  logic              clear_underflow = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] dac_tdata;
  logic              dac_tvalid;
  logic              busy;
  logic              done;
  logic              underflow;
  logic [LEN_W-1:0]  words_left;

  axis_dac_playout #(.DATA_W(DATA_W), .LEN_W(LEN_W), .IDLE_WORD('0)) dut (
    .axis_clk        (clk),
    .rst             (rst),
    .trigger         (trigger),
    .abort           (abort),
    .num_words       (num_words),
    .clear_underflow (clear_underflow),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .dac_tdata       (dac_tdata),
    .dac_tvalid      (dac_tvalid),
    .busy            (busy),
    .done            (done),
    .underflow       (underflow),
    .words_left      (words_left)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int prints = 0;

  task automatic chk_w(input string nm, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic chk_i(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  // Upstream FIFO: an endless numbered word stream, advanced on each read
  int src_idx = 0;
  int valid_mode = 0;  // 0 always valid, 1 random, 3 empty

  function automatic logic [DATA_W-1:0] word_of(input int idx);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < 8; k++) begin
      w[k*32 +: 32] = (32'(idx) * 32'h9E37_79B1 + 32'(k) * 32'h0123_4567) ^ 32'hA5A5_0000;
    end
    return w;
  endfunction

  always @(negedge clk) begin
    #2;
    s_axis_tdata  = word_of(src_idx);
    s_axis_tvalid = (valid_mode == 0) ? 1'b1 :
                    (valid_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  // Behavioural model: mode 0 idle, 1 playing, 2 finishing
  int                m_mode = 0;
  int                m_left = 0;
  logic              m_acc = 1'b0;
  logic              exp_tvalid = 1'b0;
  logic [DATA_W-1:0] exp_tdata = '0;
  logic              exp_done = 1'b0;
  logic              exp_uf = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_left = 0; exp_tvalid = 1'b0; exp_tdata = '0; exp_done = 1'b0; exp_uf = 1'b0;
    end else begin
      m_acc      = (m_mode == 1) && !abort && s_axis_tvalid;
      exp_tvalid = m_acc;
      exp_tdata  = m_acc ? s_axis_tdata : '0;
      if ((m_mode == 1) && !abort && !s_axis_tvalid) exp_uf = 1'b1;
      else if (clear_underflow) exp_uf = 1'b0;
      if (m_mode == 0) begin
        if (trigger) begin
          m_left = int'(num_words);
          m_mode = (num_words == 0) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (abort) begin
          m_mode = 0;
          m_left = 0;
        end else if (m_acc) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 2;
        end
      end else begin
        m_mode = 0;
      end
      exp_done = (m_mode == 2);
      if (m_acc) src_idx++;
    end
  end

  task automatic field(input string nm, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] e,
                       inout logic err);
    if (a !== e) begin
      err = 1'b1;
      if (prints < 30) begin
        prints++;
        $display("FAIL cyc_%s at %0t: got %0h want %0h", nm, $time, a, e);
      end
    end
  endtask

  // Per-cycle compare against the model, plus DUT-side event counters
  int n_played = 0;
  int n_done = 0;

  always @(negedge clk) begin
    logic err;
    if (!rst) begin
      err = 1'b0;
      field("tvalid", DATA_W'(dac_tvalid), DATA_W'(exp_tvalid), err);
      field("tdata", dac_tdata, exp_tdata, err);
      field("done", DATA_W'(done), DATA_W'(exp_done), err);
      field("underflow", DATA_W'(underflow), DATA_W'(exp_uf), err);
      field("words_left", DATA_W'(words_left), DATA_W'(m_left), err);
      field("busy", DATA_W'(busy), DATA_W'(m_mode != 0), err);
      field("tready", DATA_W'(s_axis_tready), DATA_W'((m_mode == 1) && !abort), err);
      total++;
      if (err) bad++;
      if (dac_tvalid) n_played++;
      if (done) n_done++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Trigger a burst and record per-cycle flags; valid is withheld for cycles [gs, gs+gl)
  task automatic burst(input logic [LEN_W-1:0] n, input int ncyc, input int gs, input int gl,
                       output logic [31:0] tv, output logic [31:0] dn, output logic [31:0] bz,
                       output logic [31:0] rdy, output logic [DATA_W-1:0] d1);
    tv = '0; dn = '0; bz = '0; rdy = '0; d1 = '0;
    num_words = n;
    trigger   = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      tv[i] = dac_tvalid; dn[i] = done; bz[i] = busy; rdy[i] = s_axis_tready;
      if (i == 1) d1 = dac_tdata;
      #1;
      trigger    = 1'b0;
      valid_mode = (i >= gs && i < gs + gl) ? 3 : 0;
    end
  endtask

  function automatic int ones(input logic [31:0] v);
    int c = 0;
    for (int i = 0; i < 32; i++) if (v[i]) c++;
    return c;
  endfunction

  initial begin
    logic [31:0]       tv, dn, bz, rdy;
    logic [DATA_W-1:0] d1;
    int                i0, p0, q0, cnt, first, last, gaps;

    #1 rst = 1'b1;
    step(3);
    chk_i("reset_tvalid", int'(dac_tvalid), 0);
    chk_i("reset_words_left", int'(words_left), 0);
    chk_i("reset_tready", int'(s_axis_tready), 0);
    chk_w("reset_tdata", dac_tdata, '0);
    rst = 1'b0;
    step(2);
    chk_i("idle_busy", int'(busy), 0);

    // Four-word burst: valid two cycles after trigger, done with last word
    i0 = src_idx;
    burst(16'd4, 8, 99, 0, tv, dn, bz, rdy, d1);
    chk_i("b4_tvalid_pattern", int'(tv), 32'h1E);
    chk_i("b4_done_pattern", int'(dn), 32'h10);
    chk_i("b4_busy_pattern", int'(bz), 32'h1F);
    chk_w("b4_first_word", d1, word_of(i0));

    // Eight-word burst with a three-cycle FIFO gap
    clear_underflow = 1'b1; step(1); clear_underflow = 1'b0;
    burst(16'd8, 16, 2, 3, tv, dn, bz, rdy, d1);
    first = -1; last = -1; gaps = 0;
    for (int i = 0; i < 16; i++) if (tv[i]) begin if (first < 0) first = i; last = i; end
    for (int i = 0; i < 16; i++) if (i > first && i < last && !tv[i]) gaps++;
    chk_i("gap_words_out", ones(tv), 8);
    chk_i("gap_idle_cycles", gaps, 3);
    chk_i("gap_done_count", ones(dn), 1);
    chk_i("gap_underflow_set", int'(underflow), 1);
    step(3);
    chk_i("gap_underflow_sticky", int'(underflow), 1);
    clear_underflow = 1'b1; step(1); clear_underflow = 1'b0;
    chk_i("gap_underflow_cleared", int'(underflow), 0);

    // Zero-length burst
    burst(16'd0, 6, 99, 0, tv, dn, bz, rdy, d1);
    chk_i("zero_tvalid", int'(tv), 0);
    chk_i("zero_tready", int'(rdy), 0);
    chk_i("zero_done_pattern", int'(dn), 32'h1);

    // Abort after two of six words
    p0 = n_played; q0 = n_done;
    num_words = 16'd6; trigger = 1'b1; step(1); trigger = 1'b0;
    step(2);
    abort = 1'b1; #1;
    chk_i("abort_tready_drop", int'(s_axis_tready), 0);
    step(1);
    chk_i("abort_words_left", int'(words_left), 0);
    chk_i("abort_busy", int'(busy), 0);
    abort = 1'b0;
    step(3);
    chk_i("abort_words_played", n_played - p0, 2);
    chk_i("abort_no_done", n_done - q0, 0);
    burst(16'd3, 8, 99, 0, tv, dn, bz, rdy, d1);
    chk_i("after_abort_words", ones(tv), 3);
    chk_i("after_abort_done", ones(dn), 1);

    // Re-trigger while playing is ignored
    p0 = n_played; q0 = n_done;
    num_words = 16'd5; trigger = 1'b1; step(1); trigger = 1'b0;
    step(1);
    num_words = 16'd9; trigger = 1'b1; step(1); trigger = 1'b0;
    step(10);
    chk_i("retrig_words", n_played - p0, 5);
    chk_i("retrig_done", n_done - q0, 1);

    // Asynchronous reset mid-burst
    num_words = 16'd10; trigger = 1'b1; step(1); trigger = 1'b0;
    step(2);
    chk_i("pre_rst_tvalid", int'(dac_tvalid), 1);
    chk_i("pre_rst_words_left", int'(words_left), 8);
    rst = 1'b1; #1;
    chk_i("rst_tvalid", int'(dac_tvalid), 0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_words_left", int'(words_left), 0);
    chk_i("rst_tready", int'(s_axis_tready), 0);
    chk_w("rst_tdata", dac_tdata, '0);
    step(2);
    rst = 1'b0;
    step(2);

    // Randomized traffic, checked cycle by cycle against the model
    valid_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      trigger         = ($urandom_range(0, 15) == 0);
      num_words       = LEN_W'($urandom_range(0, 12));
      abort           = ($urandom_range(0, 39) == 0);
      clear_underflow = ($urandom_range(0, 29) == 0);
      step(1);
    end
    trigger = 1'b0; abort = 1'b0; clear_underflow = 1'b0; valid_mode = 0;
    step(20);

    // Maximum-length burst
    p0 = n_played; q0 = n_done;
    num_words = 16'hFFFF; trigger = 1'b1; step(1); trigger = 1'b0;
    cnt = 0;
    while (busy && cnt < 70000) begin
      step(1);
      cnt++;
    end
    chk_i("max_finished_in_budget", int'(cnt < 70000), 1);
    step(2);
    chk_i("max_words", n_played - p0, 65535);
    chk_i("max_done", n_done - q0, 1);
    chk_i("max_words_left", int'(words_left), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
